// File: rtl/barrido_teclado.sv
// Keypad matrix scanner: rotating column strobe, row synchronizer, press/release
// debounce, and a single-entry valid/ready key output register.
module barrido_teclado #(
  parameter int   ROWS       = 4,
  parameter int   COLS       = 4,
  parameter int   WAIT_TIME  = 10,
  parameter int   DEBOUNCE   = 4,
  parameter logic ACTIVE_LOW = 1'b1,
  parameter int   CODE_W     = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = (WAIT_TIME > 0) ? $clog2(WAIT_TIME + 1) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  // Handshake: key_code/key_valid form one output slot; a key transfers on any
  // cycle where key_valid && key_ready. key_code is held while valid and unaccepted.

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ROWS-1:0]   row_s1_q, row_s2_q;
  logic [TW-1:0]     cnt_q;
  logic [COLS-1:0]   col_reg_q;
  logic [CW-1:0]     ci_q;
  logic [RW-1:0]     r_q;
  logic [DW-1:0]     deb_q, rel_q;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q, overrun_q;

  logic [ROWS-1:0]   rs;
  logic [RW-1:0]     r_low_d;
  logic              sample, row_hit, rotate_d, confirm_d, released_d;
  logic [CODE_W-1:0] code_d;

  always_comb begin
    rs         = row_s2_q ^ {ROWS{ACTIVE_LOW}};
    sample     = (cnt_q == TW'(WAIT_TIME));
    row_hit    = rs[r_q];
    confirm_d  = sample && (state_q == PRESS) && row_hit && (deb_q == DW'(DEBOUNCE - 1));
    released_d = sample && (state_q == RELEASE) && !row_hit && (rel_q == DW'(DEBOUNCE - 1));
    rotate_d   = (sample && (state_q == SCAN) && (rs == '0)) ||
                 (sample && (state_q == PRESS) && !row_hit) || released_d;
    code_d     = CODE_W'(r_q) * CODE_W'(COLS) + CODE_W'(ci_q);
    // Descending walk so the lowest-index active row wins.
    r_low_d    = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rs[i]) r_low_d = RW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      row_s1_q    <= {ROWS{ACTIVE_LOW}};
      row_s2_q    <= {ROWS{ACTIVE_LOW}};
      cnt_q       <= '0;
      col_reg_q   <= COLS'(1);
      ci_q        <= '0;
      r_q         <= '0;
      deb_q       <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      overrun_q <= 1'b0;
      cnt_q     <= sample ? '0 : cnt_q + TW'(1);

      if (key_valid_q && key_ready) key_valid_q <= 1'b0;

      if (rotate_d) begin
        col_reg_q <= {col_reg_q[COLS-2:0], col_reg_q[COLS-1]};
        ci_q      <= (ci_q == CW'(COLS - 1)) ? '0 : ci_q + CW'(1);
      end

      unique case (state_q)
        SCAN: begin
          if (sample && (rs != '0)) begin
            r_q     <= r_low_d;
            deb_q   <= '0;
            state_q <= PRESS;
          end
        end
        PRESS: begin
          if (sample) begin
            if (!row_hit) begin
              state_q <= SCAN;
            end else if (confirm_d) begin
              rel_q   <= '0;
              state_q <= RELEASE;
            end else begin
              deb_q <= deb_q + DW'(1);
            end
          end
        end
        RELEASE: begin
          if (sample) begin
            if (row_hit)         rel_q <= '0;
            else if (released_d) begin
              rel_q   <= '0;
              state_q <= SCAN;
            end else             rel_q <= rel_q + DW'(1);
          end
        end
        default: state_q <= SCAN;
      endcase

      // A commit overrides the accept-clear above; a full slot drops the key.
      if (confirm_d) begin
        if (!key_valid_q || key_ready) begin
          key_code_q  <= code_d;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign col       = col_reg_q ^ {COLS{ACTIVE_LOW}};
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: doc/barrido_teclado.md
# barrido_teclado

Parametrised keypad matrix scanner. It drives a one-hot rotating column strobe, samples the row lines, and debounces a detected key. It emits the key's linear code through a single-entry valid/ready output register. It sits between the physical keypad pins and the digit-entry logic, and replaces the free-running column sweep with a scan-detect-debounce-release sequence.

## Interface
Parameters:
- ROWS, 4, number of row inputs (≥2)
- COLS, 4, number of column outputs (≥2)
- WAIT_TIME, 10, dwell counter terminal value; one column step lasts WAIT_TIME+1 cycles (≥3)
- DEBOUNCE, 4, number of consecutive confirming samples for press and release (≥1)
- ACTIVE_LOW, 1'b1, when 1 both `col` outputs and `row` inputs are active-low
- CODE_W, $clog2(ROWS*COLS), width of `key_code`

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row  in  ROWS  raw row lines (asynchronous; active level per ACTIVE_LOW)
- col  out  COLS  column strobes, one-hot (inverted when ACTIVE_LOW)
- key_code  out  CODE_W  row_index*COLS + col_index of the confirmed key
- key_valid  out  1  key_code holds an unconsumed key
- key_ready  in  1  consumer accepts the key when key_valid && key_ready
- overrun  out  1  one-cycle pulse: a confirmed key was dropped because the output was full

## Operation
- `row` passes through a 2-flop synchronizer, then is normalised to active-high (inverted if ACTIVE_LOW). All decisions use the synchronized, normalised value `rs`.
- Dwell counter runs 0..WAIT_TIME. A "sample point" is the cycle where the counter equals WAIT_TIME. The counter then returns to 0.
- Internal one-hot `col_reg`, plus a column index `ci` in 0..COLS-1. A rotation moves bit i to bit i+1, with the MSB wrapping to bit 0, and sets ci to (ci+1) mod COLS. Rotations happen only in SCAN.
- FSM states and transitions:
  - SCAN:
    - At a sample point with rs==0: rotate.
    - At a sample point with rs!=0: latch `r` = lowest-index active row and the current ci. Clear the debounce count, hold the column, go to PRESS.
  - PRESS:
    - At each sample point, if rs[r]==1, increment the count.
    - When the count reaches DEBOUNCE, the key is confirmed: commit, then go to RELEASE.
    - If rs[r]==0 at any sample point: go to SCAN and rotate on that same sample point.
  - RELEASE:
    - Hold the column.
    - When rs[r]==0 at a sample point, increment the release count. When rs[r]==1, clear it.
    - When the release count reaches DEBOUNCE, go to SCAN and rotate on that sample point.
- Commit rules:
  - If key_valid==0, or key_ready==1 in the same cycle, load key_code = r*COLS+ci and key_valid stays or becomes 1.
  - Otherwise, keep the old key and pulse overrun.
- Output handshake:
  - key_valid clears on key_valid && key_ready unless a commit happens in the same cycle.
  - key_code is stable while key_valid is 1 and not yet accepted.
- A held key produces exactly one commit. There is no auto-repeat.
- Other active rows are ignored while a key is being tracked.
- Code arithmetic is unsigned in CODE_W bits; the maximum is ROWS*COLS-1.

## Timing
- Reset values:
  - col_reg = one-hot bit 0, so col = ~1 when ACTIVE_LOW
  - ci=0, counter=0, state SCAN, both debounce counts 0
  - key_valid=0, key_code=0, overrun=0
  - synchronizer flops cleared to the inactive level
- Reset takes priority over every event, including mid-PRESS and mid-RELEASE. The next cycle behaves as power-up.
- Column period in SCAN is WAIT_TIME+1 cycles. A full sweep is COLS*(WAIT_TIME+1) cycles.
- Row-to-decision latency is 2 cycles (synchronizer). WAIT_TIME≥3 guarantees settled rows at the sample point.
- Press latency:
  - The first detecting sample is S0; the confirmation is sample S_DEBOUNCE.
  - key_valid rises on the clock edge ending S_DEBOUNCE's cycle, i.e. it is visible the following cycle.
  - A stable press is therefore visible DEBOUNCE*(WAIT_TIME+1)+1 cycles after S0.
- overrun pulses in the cycle after the dropped commit and lasts exactly one cycle.
- A simultaneous accept and commit leaves key_valid at 1 with the new code and no overrun.

## Test plan
- Reset/idle (ROWS=COLS=4, WAIT_TIME=3, ACTIVE_LOW=1, rows high):
  - col = 4'b1110 after reset.
  - col steps to 1101, 1011, 0111, 1110 every 4 cycles.
  - key_valid stays 0.
- Single press: row 2 pulled low while col 1 is active, held for 40 cycles, key_ready=1.
  - key_code=9 and key_valid high for exactly 1 cycle, 17 cycles after the detecting sample (DEBOUNCE=4).
  - The column holds at 1101 until release plus 4 clean samples, then resumes rotation at 1011.
- Bounce: row 0 low for 2 sample points, then high.
  - No key_valid.
  - Scan resumes from the next column on the failing sample.
- Backpressure: key_ready=0, press code 5, release, then press code 10.
  - key_code stays 5 and one overrun pulse occurs.
  - Asserting key_ready gives a single handshake and key_valid then drops to 0.
- Hold, no repeat: a key held for 200 cycles yields exactly one commit.
  - Releasing with a 1-sample glitch back to pressed restarts the release count.
- Reset mid-operation: assert rst during PRESS and again while key_valid=1.
  - All outputs return to their reset values the next cycle.
  - The scan restarts at col index 0.
